// File: rtl/gnn_pkg.sv
// Shared types and constants for the GNN neighbourhood aggregation engine.
package gnn_pkg;

  localparam int unsigned NUM_FEAT = 4;
  localparam int unsigned RELU_W   = 15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } aggr_state_t;

  // Aggregate width: one extra bit per doubling of the node count keeps the sum exact.
  function automatic int unsigned aggr_width(input int unsigned num_nodes);
    return RELU_W + $clog2(num_nodes);
  endfunction

endpackage

// File: rtl/gnn_aggr_lane.sv
// One destination node's four feature accumulators.
module gnn_aggr_lane
  import gnn_pkg::*;
#(
  parameter int unsigned AGGR_W = 17
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         en,
  input  logic [NUM_FEAT*RELU_W-1:0]   feat,
  output logic [NUM_FEAT*AGGR_W-1:0]   acc
);

  logic [AGGR_W-1:0] acc_q [NUM_FEAT];
  logic [AGGR_W-1:0] feat_ext [NUM_FEAT];

  // Zero-extend each feature; a negative value (bit 14 set) counts as zero.
  always_comb begin
    for (int f = 0; f < NUM_FEAT; f++) begin
      feat_ext[f] = '0;
      if (!feat[f*RELU_W + RELU_W - 1]) begin
        feat_ext[f] = {{(AGGR_W - RELU_W + 1){1'b0}}, feat[f*RELU_W +: RELU_W-1]};
      end
    end
  end

  // Accumulate on enable; clear at transaction capture.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int f = 0; f < NUM_FEAT; f++) acc_q[f] <= '0;
    end else if (en) begin
      for (int f = 0; f < NUM_FEAT; f++) acc_q[f] <= acc_q[f] + feat_ext[f];
    end
  end

  // Pack the accumulators onto the output bus.
  always_comb begin
    acc = '0;
    for (int f = 0; f < NUM_FEAT; f++) acc[f*AGGR_W +: AGGR_W] = acc_q[f];
  end

endmodule

// File: rtl/gnn_aggregator.sv
// Neighbourhood aggregation engine: sums node features over the adjacency,
// one source node per cycle, all destinations in parallel.
// Optional feature: define GNN_AGGR_SELF_LOOP_EN to add each node's own features.
module gnn_aggregator
  import gnn_pkg::*;
#(
  parameter int unsigned NUM_NODES = 4,
  parameter int unsigned AGGR_W    = aggr_width(NUM_NODES)
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [NUM_NODES*NUM_FEAT*RELU_W-1:0]   relu_in,
  input  logic [NUM_NODES*NUM_NODES-1:0]         adj,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [NUM_NODES*NUM_FEAT*AGGR_W-1:0]   aggr_out
);

  localparam int unsigned SRC_W  = $clog2(NUM_NODES);
  localparam int unsigned NODE_W = NUM_FEAT * RELU_W;
  localparam logic [SRC_W-1:0] SRC_LAST = SRC_W'(NUM_NODES - 1);

`ifdef GNN_AGGR_SELF_LOOP_EN
  localparam bit SELF_LOOP = 1'b1;
`else
  localparam bit SELF_LOOP = 1'b0;
`endif

  aggr_state_t                         state_q;
  logic [SRC_W-1:0]                    src_q;
  logic [NUM_NODES*NODE_W-1:0]         feat_q;
  logic [NUM_NODES*NUM_NODES-1:0]      adj_q;
  logic                                in_ready_q;
  logic                                out_valid_q;
  logic                                capture;
  logic [NODE_W-1:0]                   src_feat;

  assign capture   = (state_q == IDLE) && in_valid;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;

  // Source mux: the current source node's features go to every lane.
  always_comb begin
    src_feat = feat_q[int'(src_q)*NODE_W +: NODE_W];
  end

  // Control FSM with capture registers and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      src_q       <= '0;
      feat_q      <= '0;
      adj_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            feat_q     <= relu_in;
            adj_q      <= adj;
            src_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= ACCUM;
          end
        end
        ACCUM: begin
          src_q <= src_q + 1'b1;
          if (src_q == SRC_LAST) begin
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  for (genvar d = 0; d < NUM_NODES; d++) begin : g_lane
    logic edge_bit;
    logic lane_en;

    // Row d of the adjacency selected by the current source.
    always_comb begin
      edge_bit = adj_q[d*NUM_NODES + int'(src_q)];
      lane_en  = (state_q == ACCUM) && (edge_bit || (SELF_LOOP && (int'(src_q) == d)));
    end

    gnn_aggr_lane #(
      .AGGR_W (AGGR_W)
    ) u_lane (
      .clk  (clk),
      .rst  (rst),
      .clr  (capture),
      .en   (lane_en),
      .feat (src_feat),
      .acc  (aggr_out[d*NUM_FEAT*AGGR_W +: NUM_FEAT*AGGR_W])
    );
  end

endmodule
